// File: rtl/fft_input_loader.sv
// Input stage for fft_control: gathers one 2048-point frame into four RAM banks, then starts the transform.
// Define FFT_LOADER_BITREV_EN to store samples in bit-reversed order; default build stores them in natural order.
module fft_input_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iVALID,
    input  logic [DATA_W-1:0] iDATA_RE,
    input  logic [DATA_W-1:0] iDATA_IM,
    output logic              oREADY,
    input  logic              iFFT_RDY,
    output logic              oSTART,
    output logic [ADDR_W-1:0] oADDR_WR,
    output logic [3:0]        oWE,
    output logic [DATA_W-1:0] oDATA_RE,
    output logic [DATA_W-1:0] oDATA_IM,
    output logic              oBUSY,
    output logic [ADDR_W+1:0] oCNT
);
    localparam int IDX_W = ADDR_W + 2;
    localparam logic [IDX_W-1:0] LAST = '1;

    // RUN_HOLD covers the cycle where the controller still shows oRDY from before iSTART.
    typedef enum logic [2:0] {LOAD, FULL, START, RUN_HOLD, RUN} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             xfer;

    assign xfer = iVALID && (state == LOAD);

`ifdef FFT_LOADER_BITREV_EN
    always_comb begin
        idx = '0;
        for (int i = 0; i < IDX_W; i++)
            idx[i] = cnt[IDX_W-1-i];
    end
`else
    assign idx = cnt;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:     if (xfer && cnt == LAST) state_nxt = FULL;
            FULL:     if (iFFT_RDY) state_nxt = START;
            START:    state_nxt = RUN_HOLD;
            RUN_HOLD: state_nxt = RUN;
            RUN:      if (iFFT_RDY) state_nxt = LOAD;
            default:  state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state  <= LOAD;
            cnt    <= '0;
            oREADY <= 1'b1;
            oSTART <= 1'b0;
            oBUSY  <= 1'b0;
        end else begin
            state  <= state_nxt;
            oREADY <= (state_nxt == LOAD);
            oSTART <= (state_nxt == START);
            oBUSY  <= (state_nxt != LOAD);
            // Wraps to 0 on the final sample, so cnt already reads 0 outside LOAD.
            if (xfer)
                cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            oWE      <= '0;
            oADDR_WR <= '0;
            oDATA_RE <= '0;
            oDATA_IM <= '0;
        end else begin
            oWE <= xfer ? (4'b0001 << idx[1:0]) : 4'b0000;
            if (xfer) begin
                oADDR_WR <= idx[IDX_W-1:2];
                oDATA_RE <= iDATA_RE;
                oDATA_IM <= iDATA_IM;
            end
        end
    end

    assign oCNT = cnt;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader: frame fill, start handshake, backpressure, gaps and mid-frame reset.
module tb_fft_input_loader;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int NPTS   = 2048;

    logic              iCLK = 1'b0;
    logic              iRESET = 1'b0;
    logic              iVALID = 1'b0;
    logic [DATA_W-1:0] iDATA_RE = '0;
    logic [DATA_W-1:0] iDATA_IM = '0;
    logic              oREADY;
    logic              iFFT_RDY = 1'b0;
    logic              oSTART;
    logic [ADDR_W-1:0] oADDR_WR;
    logic [3:0]        oWE;
    logic [DATA_W-1:0] oDATA_RE;
    logic [DATA_W-1:0] oDATA_IM;
    logic              oBUSY;
    logic [ADDR_W+1:0] oCNT;

    fft_input_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iVALID(iVALID),
        .iDATA_RE(iDATA_RE), .iDATA_IM(iDATA_IM), .oREADY(oREADY),
        .iFFT_RDY(iFFT_RDY), .oSTART(oSTART), .oADDR_WR(oADDR_WR),
        .oWE(oWE), .oDATA_RE(oDATA_RE), .oDATA_IM(oDATA_IM),
        .oBUSY(oBUSY), .oCNT(oCNT)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, obs, exp);
        end
    endtask

    // Write monitor, sampled on the falling edge.
    int          we_cnt, start_cnt, oh_bad;
    int          bank_cnt [4];
    int          hits     [4][512];
    logic [15:0] mem_re   [4][512];
    logic [15:0] mem_im   [4][512];

    always @(negedge iCLK) begin
        if (oSTART) start_cnt++;
        if (oWE != 4'b0000) begin
            we_cnt++;
            if ($countones(oWE) != 1) oh_bad++;
            else
                for (int b = 0; b < 4; b++)
                    if (oWE[b]) begin
                        bank_cnt[b]++;
                        hits[b][oADDR_WR]++;
                        mem_re[b][oADDR_WR] = oDATA_RE;
                        mem_im[b][oADDR_WR] = oDATA_IM;
                    end
        end
    end

    task automatic clr_mon();
        @(posedge iCLK);
        #1;
        we_cnt = 0; start_cnt = 0; oh_bad = 0;
        for (int b = 0; b < 4; b++) begin
            bank_cnt[b] = 0;
            for (int a = 0; a < 512; a++) begin
                hits[b][a] = 0; mem_re[b][a] = '0; mem_im[b][a] = '0;
            end
        end
    endtask

    function automatic int map_idx(input int n);
        int r;
`ifdef FFT_LOADER_BITREV_EN
        r = 0;
        for (int i = 0; i < 11; i++)
            if (((n >> i) & 1) != 0) r = r | (1 << (10 - i));
`else
        r = n;
`endif
        return r;
    endfunction

    // Offers samples n = 0.. at the given duty; returns at the edge of the last transfer.
    task automatic load_frame(input string tag, input int duty, input int stop_at);
        int n = 0;
        int guard = 0;
        int cnt_bad = 0;
        while (n < stop_at && guard < 10000) begin
            @(negedge iCLK);
            if (oCNT !== n[10:0]) cnt_bad++;
            iVALID   = (duty >= 100) ? 1'b1 : ($urandom_range(99) < duty);
            iDATA_RE = n[15:0];
            iDATA_IM = 16'(-n);
            if (iVALID && oREADY) n++;
            guard++;
        end
        @(posedge iCLK);
        chk({tag, "_accepted"}, n, stop_at);
        chk({tag, "_ocnt_track"}, cnt_bad, 0);
    endtask

    task automatic check_frame(input string tag);
        int data_bad = 0;
        int dup_bad = 0;
        int p;
        repeat (2) @(negedge iCLK);
        chk({tag, "_we_pulses"}, we_cnt, NPTS);
        chk({tag, "_onehot"}, oh_bad, 0);
        for (int b = 0; b < 4; b++) chk({tag, "_bank_cnt"}, bank_cnt[b], 512);
        for (int n = 0; n < NPTS; n++) begin
            p = map_idx(n);
            if (mem_re[p % 4][p / 4] !== n[15:0] || mem_im[p % 4][p / 4] !== 16'(-n)) data_bad++;
        end
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 512; a++)
                if (hits[b][a] != 1) dup_bad++;
        chk({tag, "_data"}, data_bad, 0);
        chk({tag, "_once_each"}, dup_bad, 0);
    endtask

    task automatic wait_ready(input string tag);
        int t = 0;
        while (!oREADY && t < 20) begin
            @(negedge iCLK);
            t++;
        end
        chk(tag, oREADY, 1);
    endtask

    initial begin
        int bad;
        // Reset
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        chk("rst_ready", oREADY, 1);
        chk("rst_we", oWE, 0);
        chk("rst_addr", oADDR_WR, 0);
        chk("rst_dre", oDATA_RE, 0);
        iRESET = 1'b1;
        @(negedge iCLK);
        chk("idle_ready", oREADY, 1);
        chk("idle_we", oWE, 0);
        chk("idle_start", oSTART, 0);
        chk("idle_cnt", oCNT, 0);
        chk("idle_busy", oBUSY, 0);

        // Back-to-back frame, controller idle
        iFFT_RDY = 1'b1;
        clr_mon();
        load_frame("b2b", 100, NPTS);
        @(negedge iCLK);
        iVALID = 1'b0;
        chk("full_ready", oREADY, 0);
        chk("full_busy", oBUSY, 1);
        chk("full_cnt", oCNT, 0);
        chk("full_start", oSTART, 0);
        chk("last_we", oWE, 4'b1000);
        @(negedge iCLK);
        chk("start_pulse", oSTART, 1);
        @(negedge iCLK);
        chk("start_one_cycle", oSTART, 0);
        check_frame("b2b");
        chk("b2b_starts", start_cnt, 1);
`ifdef FFT_LOADER_BITREV_EN
        chk("brv_n1", mem_re[0][256], 1);
        chk("brv_n2", mem_re[0][128], 2);
        chk("brv_n1024", mem_re[1][0], 1024);
`else
        chk("nat_n5", mem_re[1][1], 5);
        chk("nat_n5_im", mem_im[1][1], 16'hfffb);
`endif
        wait_ready("b2b_back_to_load");

        // Controller busy after fill, then long transform
        iFFT_RDY = 1'b0;
        clr_mon();
        load_frame("hold", 100, NPTS);
        @(negedge iCLK);
        chk("hold_last_we", oWE, 4'b1000);
        bad = 0;
        repeat (40) begin
            @(negedge iCLK);
            if (oSTART || oREADY || oWE != 4'b0000) bad++;
        end
        chk("hold_40_quiet", bad, 0);
        iFFT_RDY = 1'b1;
        @(negedge iCLK);
        chk("hold_start", oSTART, 1);
        iFFT_RDY = 1'b0;
        bad = 0;
        repeat (500) begin
            @(negedge iCLK);
            if (oWE != 4'b0000 || oREADY || oSTART || !oBUSY) bad++;
        end
        chk("run_500_blocked", bad, 0);
        chk("hold_starts", start_cnt, 1);
        chk("hold_writes", we_cnt, NPTS);
        iVALID = 1'b0;
        iFFT_RDY = 1'b1;
        @(negedge iCLK);
        chk("run_done_ready", oREADY, 1);
        chk("run_done_busy", oBUSY, 0);
        chk("run_done_cnt", oCNT, 0);

        // Random gaps
        clr_mon();
        load_frame("gaps", 50, NPTS);
        @(negedge iCLK);
        iVALID = 1'b0;
        check_frame("gaps");
        chk("gaps_starts", start_cnt, 1);
        wait_ready("gaps_back_to_load");

        // Reset mid-frame
        load_frame("abort", 100, 1000);
        @(negedge iCLK);
        iVALID = 1'b0;
        chk("abort_cnt", oCNT, 1000);
        iRESET = 1'b0;
        @(negedge iCLK);
        chk("abort_rst_cnt", oCNT, 0);
        chk("abort_rst_ready", oREADY, 1);
        chk("abort_rst_we", oWE, 0);
        iRESET = 1'b1;
        clr_mon();
        repeat (5) @(negedge iCLK);
        chk("abort_no_start", start_cnt, 0);
        load_frame("reload", 100, NPTS);
        @(negedge iCLK);
        iVALID = 1'b0;
        check_frame("reload");
        chk("reload_starts", start_cnt, 1);
        wait_ready("reload_back_to_load");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
